// File: rtl/perf_event_counters_if.sv
// Bundle of control, event and read-port signals for perf_event_counters.
// The master side drives events and requests; the slave side returns counts and status.
interface perf_event_counters_if #(
    parameter int NUM_EVT = 6,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = 3
);
    logic               start;
    logic               halt;
    logic               clr;
    logic [NUM_EVT-1:0] evt;
    logic               rd_req;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_valid;
    logic [CNT_W-1:0]   rd_data;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [NUM_EVT-1:0] ovf;
    logic [1:0]         state;

    modport master (
        output start, halt, clr, evt, rd_req, rd_idx,
        input  rd_valid, rd_data, cycle_cnt, ovf, state
    );

    modport slave (
        input  start, halt, clr, evt, rd_req, rd_idx,
        output rd_valid, rd_data, cycle_cnt, ovf, state
    );
endinterface

// File: rtl/perf_event_counters.sv
// Per-event performance counter bank with cycle counter and indexed one-cycle read port.
// Define PERF_SAT_EN to make counters saturate at all-ones instead of wrapping.
module perf_event_counters #(
    parameter int NUM_EVT = 6,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    perf_event_counters_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FROZEN = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e             state_r;
    state_e             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r     [NUM_EVT];
    logic [CNT_W-1:0]   cnt_nxt_s [NUM_EVT];
    logic [CNT_W-1:0]   cyc_r;
    logic [CNT_W-1:0]   cyc_nxt_s;
    logic [NUM_EVT-1:0] ovf_r;
    logic [NUM_EVT-1:0] ovf_nxt_s;
    logic               rd_valid_r;
    logic [CNT_W-1:0]   rd_data_r;
    logic [CNT_W-1:0]   rd_sel_s;
    logic               run_s;

    // Returns {hit_max, next_value}; hit_max flags an increment attempted at all-ones.
    function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] v);
        logic [CNT_W:0] r;
        if (v == CNT_MAX) begin
`ifdef PERF_SAT_EN
            r = {1'b1, CNT_MAX};
`else
            r = {1'b1, {CNT_W{1'b0}}};
`endif
        end else begin
            r = {1'b0, v + {{(CNT_W-1){1'b0}}, 1'b1}};
        end
        return r;
    endfunction

    assign run_s = (state_r == ST_RUN) && !bus.clr;

    // Next-state logic; clr overrides everything, encoding 11 recovers to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.clr) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   if (bus.start) state_nxt_s = ST_RUN;    else state_nxt_s = ST_IDLE;
                ST_RUN:    if (bus.halt)  state_nxt_s = ST_FROZEN; else state_nxt_s = ST_RUN;
                ST_FROZEN: state_nxt_s = ST_FROZEN;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Counter, cycle and overflow next values.
    always_comb begin
        logic [CNT_W:0] stp_v;
        stp_v     = '0;
        cyc_nxt_s = cyc_r;
        ovf_nxt_s = ovf_r;
        for (int i = 0; i < NUM_EVT; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
        end
        if (bus.clr) begin
            cyc_nxt_s = '0;
            ovf_nxt_s = '0;
            for (int i = 0; i < NUM_EVT; i++) begin
                cnt_nxt_s[i] = '0;
            end
        end else if (run_s) begin
            stp_v     = cnt_step(cyc_r);
            cyc_nxt_s = stp_v[CNT_W-1:0];
            for (int i = 0; i < NUM_EVT; i++) begin
                if (bus.evt[i]) begin
                    stp_v        = cnt_step(cnt_r[i]);
                    cnt_nxt_s[i] = stp_v[CNT_W-1:0];
                    ovf_nxt_s[i] = ovf_r[i] | stp_v[CNT_W];
                end else begin
                    cnt_nxt_s[i] = cnt_r[i];
                end
            end
        end else begin
            cyc_nxt_s = cyc_r;
        end
    end

    // Read mux; an index with no matching channel yields zero.
    always_comb begin
        rd_sel_s = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            rd_sel_s = rd_sel_s | ({CNT_W{bus.rd_idx == IDX_W'(i)}} & cnt_r[i]);
        end
    end

    // State, counter and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cyc_r   <= '0;
            ovf_r   <= '0;
            for (int i = 0; i < NUM_EVT; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            state_r <= state_nxt_s;
            cyc_r   <= cyc_nxt_s;
            ovf_r   <= ovf_nxt_s;
            for (int i = 0; i < NUM_EVT; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Read port samples pre-update counter values, so a read alongside clr sees old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            rd_valid_r <= bus.rd_req;
            if (bus.rd_req) begin
                rd_data_r <= rd_sel_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign bus.state     = state_r;
    assign bus.cycle_cnt = cyc_r;
    assign bus.ovf       = ovf_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_data   = rd_data_r;
endmodule

// File: tb/tb_perf_event_counters.sv
// Self-checking bench for perf_event_counters: a 32-bit and a 4-bit instance share stimulus
// and are compared each cycle against a behavioural model.
module tb_perf_event_counters;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       t_start, t_halt, t_clr, t_rd_req;
    logic [5:0] t_evt;
    logic [2:0] t_idx;

    always #5 clk = ~clk;

    perf_event_counters_if #(.NUM_EVT(6), .CNT_W(32), .IDX_W(3)) bus_a ();
    perf_event_counters_if #(.NUM_EVT(6), .CNT_W(4),  .IDX_W(3)) bus_b ();

    perf_event_counters #(.NUM_EVT(6), .CNT_W(32), .IDX_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    perf_event_counters #(.NUM_EVT(6), .CNT_W(4), .IDX_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    assign bus_a.start = t_start;  assign bus_b.start = t_start;
    assign bus_a.halt = t_halt;    assign bus_b.halt = t_halt;
    assign bus_a.clr = t_clr;      assign bus_b.clr = t_clr;
    assign bus_a.evt = t_evt;      assign bus_b.evt = t_evt;
    assign bus_a.rd_req = t_rd_req; assign bus_b.rd_req = t_rd_req;
    assign bus_a.rd_idx = t_idx;   assign bus_b.rd_idx = t_idx;

    int              n_vec = 0;
    int              n_bad = 0;
    int              cw [2] = '{32, 4};
`ifdef PERF_SAT_EN
    bit              sat = 1'b1;
`else
    bit              sat = 1'b0;
`endif
    int              m_state [2];
    longint unsigned m_cnt [2][6];
    longint unsigned m_cyc [2];
    logic [5:0]      m_ovf [2];
    logic            m_rv [2];
    longint unsigned m_rd [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0;
            m_cyc[d]   = 0;
            m_ovf[d]   = '0;
            m_rv[d]    = 1'b0;
            m_rd[d]    = 0;
            for (int i = 0; i < 6; i++) m_cnt[d][i] = 0;
        end
    endfunction

    // One clock edge of the spec's rules, applied to the inputs currently driven.
    function automatic void model_step(input int d);
        longint unsigned lim;
        lim = (64'd1 << cw[d]) - 64'd1;
        m_rv[d] = t_rd_req;
        if (t_rd_req) m_rd[d] = (int'(t_idx) < 6) ? m_cnt[d][t_idx] : 0;
        if (t_clr) begin
            m_state[d] = 0;
            m_cyc[d]   = 0;
            m_ovf[d]   = '0;
            for (int i = 0; i < 6; i++) m_cnt[d][i] = 0;
        end else if (m_state[d] == 1) begin
            m_cyc[d] = (m_cyc[d] == lim) ? (sat ? lim : 0) : m_cyc[d] + 1;
            for (int i = 0; i < 6; i++) begin
                if (t_evt[i]) begin
                    if (m_cnt[d][i] == lim) begin
                        m_cnt[d][i] = sat ? lim : 0;
                        m_ovf[d][i] = 1'b1;
                    end else begin
                        m_cnt[d][i] = m_cnt[d][i] + 1;
                    end
                end
            end
            if (t_halt) m_state[d] = 2;
        end else if (m_state[d] == 0 && t_start) begin
            m_state[d] = 1;
        end
    endfunction

    task automatic check_all();
        chk("state_a", bus_a.state,     m_state[0]);
        chk("cyc_a",   bus_a.cycle_cnt, m_cyc[0]);
        chk("ovf_a",   bus_a.ovf,       m_ovf[0]);
        chk("rv_a",    bus_a.rd_valid,  m_rv[0]);
        chk("rd_a",    bus_a.rd_data,   m_rd[0]);
        chk("state_b", bus_b.state,     m_state[1]);
        chk("cyc_b",   bus_b.cycle_cnt, m_cyc[1]);
        chk("ovf_b",   bus_b.ovf,       m_ovf[1]);
        chk("rv_b",    bus_b.rd_valid,  m_rv[1]);
        chk("rd_b",    bus_b.rd_data,   m_rd[1]);
    endtask

    task automatic drive(input logic st, input logic hl, input logic cl, input logic [5:0] ev,
                         input logic rq, input logic [2:0] ix);
        t_start = st; t_halt = hl; t_clr = cl; t_evt = ev; t_rd_req = rq; t_idx = ix;
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 3'd0);
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Count 10 events on channel 0, halt on the 10th, then read it back.
        drive(1'b0, 1'b0, 1'b1, 6'h00, 1'b0, 3'd0); step();
        drive(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 3'd0); step();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, (k == 10), 1'b0, 6'h01, 1'b0, 3'd0); step();
        end
        chk("t1_state", bus_a.state, 64'd2);
        chk("t1_cyc",   bus_a.cycle_cnt, 64'd10);
        drive(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 3'd0); step();
        chk("t1_rd", bus_a.rd_data, 64'h0000000A);

        // Frozen ignores events and start.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0, 6'h3F, 1'b0, 3'd0); step();
        end
        chk("t2_state", bus_a.state, 64'd2);
        chk("t2_cyc",   bus_a.cycle_cnt, 64'd10);

        // Back-to-back reads including an out-of-range index.
        drive(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 3'd0); step();
        chk("t4_v0", bus_a.rd_valid, 64'd1);
        drive(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 3'd1); step();
        chk("t4_v1", bus_a.rd_valid, 64'd1);
        drive(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 3'd7); step();
        chk("t4_v7", bus_a.rd_valid, 64'd1);
        chk("t4_d7", bus_a.rd_data, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 3'd0); step();
        chk("t4_vlo", bus_a.rd_valid, 64'd0);

        // 17 pulses on channel 2 overflow the 4-bit instance.
        drive(1'b0, 1'b0, 1'b1, 6'h00, 1'b0, 3'd0); step();
        drive(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 3'd0); step();
        for (int k = 1; k <= 17; k++) begin
            drive(1'b0, (k == 17), 1'b0, 6'h04, 1'b0, 3'd0); step();
        end
        drive(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 3'd2); step();
        chk("t3_rd_b",  bus_b.rd_data, sat ? 64'd15 : 64'd1);
        chk("t3_ovf_b", bus_b.ovf[2], 64'd1);
        chk("t3_rd_a",  bus_a.rd_data, 64'd17);

        // clr wins over events and halt while running; read in the clr cycle sees old data.
        drive(1'b0, 1'b0, 1'b1, 6'h00, 1'b0, 3'd0); step();
        drive(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 3'd0); step();
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b0, 1'b0, 6'($urandom), 1'b0, 3'd0); step();
        end
        drive(1'b0, 1'b1, 1'b1, 6'h3F, 1'b1, 3'd5); step();
        chk("t5_state", bus_a.state, 64'd0);
        chk("t5_cyc",   bus_a.cycle_cnt, 64'd0);
        chk("t5_ovf_b", bus_b.ovf, 64'd0);
        chk("t5_rd",    bus_a.rd_valid, 64'd1);

        // Asynchronous reset between edges, then start+halt together in IDLE.
        drive(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 3'd0); step();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 6'h3F, 1'b1, 3'($urandom_range(0, 5))); step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_cnt_rd", bus_a.rd_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 3'd0); step();
        chk("t6_run", bus_a.state, 64'd1);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            drive(($urandom % 6) == 0, ($urandom % 20) == 0, ($urandom % 40) == 0,
                  6'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
